// File: rtl/decode_pkg.sv
// Shared opcode constants and ID/EX control-bundle layout for the decode stage.
package decode_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'b1000,
      OP_STORE = 4'b1001,
      OP_BR0   = 4'b1100,
      OP_BR1   = 4'b1101,
      OP_HLT   = 4'b1111
   } opcode_e;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       pc_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       hlt;
   } ctrl_t;

   // Opcodes 0xxx are ALU operations; anything not listed decodes as a no-op.
   function automatic ctrl_t decode_ctrl(input logic [3:0] opc);
      ctrl_t c;
      c = '0;
      if (!opc[3]) begin
         c.alu_op    = opc;
         c.reg_write = 1'b1;
      end else begin
         case (opc)
            OP_LOAD: begin
               c.mem_read   = 1'b1;
               c.mem_to_reg = 1'b1;
               c.alu_src    = 1'b1;
               c.reg_write  = 1'b1;
            end
            OP_STORE: begin
               c.mem_write = 1'b1;
               c.alu_src   = 1'b1;
            end
            OP_BR0, OP_BR1: c.pc_src = 1'b1;
            OP_HLT:         c.hlt    = 1'b1;
            default:        c        = '0;
         endcase
      end
      return c;
   endfunction

   // ALU and store instructions read src2 as a register operand.
   function automatic logic reads_src2(input logic [3:0] opc);
      return !opc[3] || (opc == OP_STORE);
   endfunction

endpackage

// File: rtl/regfile_np.sv
// NREGS x DATA_W register array: two combinational read ports, one write port, async clear.
module regfile_np #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int RW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RW-1:0]     i_raddr1,
   input  logic [RW-1:0]     i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   input  logic              i_we,
   input  logic [RW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_mem [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '{default: '0};
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with a single registered ID/EX bundle, load-use stall,
// write-back forwarding, flush and sticky halt.
module decode_stage
   import decode_pkg::*;
#(
   parameter  int DATA_W    = 16,
   parameter  int NREGS     = 16,
   parameter  int WB_BYPASS = 1,
   localparam int RW        = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,
   input  logic [DATA_W-1:0] pc_inc_2,
   input  logic              wb_we,
   input  logic [RW-1:0]     wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] pc_out,
   output logic [RW-1:0]     dst,
   output logic [3:0]        alu_op,
   output logic              alu_src,
   output logic              pc_src,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              hlt
);

   localparam bit BYP = (WB_BYPASS != 0);

   logic [3:0]        w_opc;
   logic [RW-1:0]     w_src1;
   logic [RW-1:0]     w_src2;
   logic [RW-1:0]     w_dst;
   ctrl_t             w_ctrl;
   logic              w_stall;
   logic              w_ready;
   logic              w_take;
   logic [DATA_W-1:0] w_rf1;
   logic [DATA_W-1:0] w_rf2;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic [DATA_W-1:0] w_imm;

   logic              r_valid;
   logic              r_halted;
   ctrl_t             r_ctrl;
   logic [RW-1:0]     r_dst;
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_pc;

   assign w_opc  = instr[15:12];
   assign w_dst  = instr[8 +: RW];
   assign w_src1 = instr[4 +: RW];
   assign w_src2 = instr[0 +: RW];
   assign w_ctrl = decode_ctrl(w_opc);
   assign w_imm  = {{(DATA_W-9){instr[8]}}, instr[8:0]};

   regfile_np #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .RW     (RW)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_raddr1 (w_src1),
      .i_raddr2 (w_src2),
      .o_rdata1 (w_rf1),
      .o_rdata2 (w_rf2),
      .i_we     (wb_we),
      .i_waddr  (wb_dst),
      .i_wdata  (wb_data)
   );

   assign w_op1 = (BYP && wb_we && (wb_dst == w_src1)) ? wb_data : w_rf1;
   assign w_op2 = (BYP && wb_we && (wb_dst == w_src2)) ? wb_data : w_rf2;

   // A held load cannot forward its result yet, so a dependent instruction waits a cycle.
   assign w_stall = r_valid && r_ctrl.mem_read &&
                    ((r_dst == w_src1) || (reads_src2(w_opc) && (r_dst == w_src2)));
   assign w_ready = (!r_valid || out_ready) && !w_stall && !r_halted;
   assign w_take  = in_valid && w_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_ctrl   <= '0;
         r_dst    <= '0;
         r_rd1    <= '0;
         r_rd2    <= '0;
         r_imm    <= '0;
         r_pc     <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_take) begin
         r_valid <= 1'b1;
         r_ctrl  <= w_ctrl;
         r_dst   <= w_dst;
         r_rd1   <= w_op1;
         r_rd2   <= w_op2;
         r_imm   <= w_imm;
         r_pc    <= pc_inc_2;
         if (w_ctrl.hlt) begin
            r_halted <= 1'b1;
         end
      end else if (out_ready) begin
         // Consumed with nothing new (or stalled): present a bubble.
         r_valid <= 1'b0;
      end
   end

   assign in_ready   = w_ready;
   assign out_valid  = r_valid;
   assign rd1        = r_rd1;
   assign rd2        = r_rd2;
   assign imm        = r_imm;
   assign pc_out     = r_pc;
   assign dst        = r_dst;
   assign alu_op     = r_ctrl.alu_op;
   assign alu_src    = r_ctrl.alu_src;
   assign pc_src     = r_ctrl.pc_src && r_valid;
   assign mem_read   = r_ctrl.mem_read;
   assign mem_write  = r_ctrl.mem_write;
   assign mem_to_reg = r_ctrl.mem_to_reg;
   assign reg_write  = r_ctrl.reg_write;
   assign hlt        = r_ctrl.hlt;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: three configurations driven in parallel
// (16/16/bypass, 32/8/bypass, 16/16/no-bypass) against a behavioural model.
module tb_decode_stage;

   localparam int CFG_DW [3] = '{16, 32, 16};
   localparam int CFG_NR [3] = '{16, 8, 16};
   localparam int CFG_BY [3] = '{1, 1, 0};

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  dst;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        pc_src;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic        rw;
      logic        hlt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] instr;
   logic [31:0] pc;
   logic        wb_we;
   logic [3:0]  wb_dst;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_ready;

   logic [2:0]       act_ir;
   logic [2:0]       act_ov;
   exp_t [2:0]       act_b;

   int checks = 0;
   int errors = 0;

   // Scoreboard ring per DUT plus model architectural state.
   exp_t        sb [3][4];
   int unsigned hd [3];
   int unsigned cnt [3];
   bit          mh [3];
   logic [31:0] mregs [3][16];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DW = CFG_DW[g];
      localparam int RW = $clog2(CFG_NR[g]);
      logic          ir, ov, asrc, psrc, mr, mw, m2r, rw, hl;
      logic [DW-1:0] rd1, rd2, imm, pco;
      logic [RW-1:0] dst;
      logic [3:0]    aop;

      decode_stage #(
         .DATA_W    (DW),
         .NREGS     (CFG_NR[g]),
         .WB_BYPASS (CFG_BY[g])
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (in_valid),
         .in_ready   (ir),
         .instr      (instr),
         .pc_inc_2   (pc[DW-1:0]),
         .wb_we      (wb_we),
         .wb_dst     (wb_dst[RW-1:0]),
         .wb_data    (wb_data[DW-1:0]),
         .flush      (flush),
         .out_valid  (ov),
         .out_ready  (out_ready),
         .rd1        (rd1),
         .rd2        (rd2),
         .imm        (imm),
         .pc_out     (pco),
         .dst        (dst),
         .alu_op     (aop),
         .alu_src    (asrc),
         .pc_src     (psrc),
         .mem_read   (mr),
         .mem_write  (mw),
         .mem_to_reg (m2r),
         .reg_write  (rw),
         .hlt        (hl)
      );

      assign act_ir[g] = ir;
      assign act_ov[g] = ov;
      assign act_b[g]  = {32'(rd1), 32'(rd2), 32'(imm), 32'(pco), 4'(dst), aop,
                          asrc, psrc, mr, mw, m2r, rw, hl};
   end

   task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
      end
   endtask

   // Model of one clock for DUT k: compare what it presents now, then advance.
   task automatic model_cycle(input int k);
      exp_t        f, n;
      int unsigned rm, s1, s2, d, wd;
      logic [31:0] dm;
      logic [3:0]  opc;
      bit          ev, hz, er, alu, st;
      rm  = CFG_NR[k] - 1;
      dm  = (CFG_DW[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      opc = instr[15:12];
      d   = instr[11:8] & rm;
      s1  = instr[7:4] & rm;
      s2  = instr[3:0] & rm;
      wd  = wb_dst & rm;
      ev  = (cnt[k] != 0);
      f   = sb[k][hd[k]];
      alu = (opc < 8);
      st  = (opc == 9);
      hz  = ev && f.mr && (f.dst == s1 || (f.dst == s2 && (alu || st)));
      er  = (!ev || out_ready) && !hz && !mh[k];

      chk($sformatf("out_valid[%0d]", k), act_ov[k], ev);
      if (ev) chk($sformatf("bundle[%0d]", k), act_b[k], f);
      else    chk($sformatf("pc_src_gated[%0d]", k), act_b[k].pc_src, 1'b0);
      chk($sformatf("in_ready[%0d]", k), act_ir[k], er);

      n     = '0;
      n.rd1 = (CFG_BY[k] != 0 && wb_we && wd == s1) ? (wb_data & dm) : mregs[k][s1];
      n.rd2 = (CFG_BY[k] != 0 && wb_we && wd == s2) ? (wb_data & dm) : mregs[k][s2];
      n.imm = {{23{instr[8]}}, instr[8:0]} & dm;
      n.pc  = pc & dm;
      n.dst = 4'(d);
      if (alu) begin
         n.alu_op = opc;
         n.rw     = 1'b1;
      end else if (opc == 8) begin
         n.mr = 1'b1; n.m2r = 1'b1; n.alu_src = 1'b1; n.rw = 1'b1;
      end else if (opc == 9) begin
         n.mw = 1'b1; n.alu_src = 1'b1;
      end else if (opc == 12 || opc == 13) begin
         n.pc_src = 1'b1;
      end else if (opc == 15) begin
         n.hlt = 1'b1;
      end

      if (flush) begin
         cnt[k] = 0;
      end else begin
         if (ev && out_ready) begin
            hd[k]  = (hd[k] + 1) % 4;
            cnt[k] = cnt[k] - 1;
         end
         if (in_valid && er) begin
            sb[k][(hd[k] + cnt[k]) % 4] = n;
            cnt[k] = cnt[k] + 1;
            if (n.hlt) mh[k] = 1'b1;
         end
      end
      if (wb_we) mregs[k][wd] = wb_data & dm;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            hd[k]  = 0;
            cnt[k] = 0;
            mh[k]  = 1'b0;
            for (int r = 0; r < 16; r++) mregs[k][r] = '0;
         end else begin
            model_cycle(k);
         end
      end
   end

   task automatic step(input bit iv, input logic [15:0] ins, input bit ordy, input bit fl,
                       input bit we, input logic [3:0] wd, input logic [31:0] wdat);
      @(posedge clk);
      #1;
      in_valid  = iv;
      instr     = ins;
      pc        = $urandom();
      out_ready = ordy;
      flush     = fl;
      wb_we     = we;
      wb_dst    = wd;
      wb_data   = wdat;
      #1;
   endtask

   task automatic chk_ready(input string nm, input bit e);
      for (int k = 0; k < 3; k++) chk($sformatf("%s_rdy[%0d]", nm, k), act_ir[k], e);
   endtask

   task automatic chk_valid(input string nm, input bit e);
      for (int k = 0; k < 3; k++) chk($sformatf("%s_ov[%0d]", nm, k), act_ov[k], e);
   endtask

   task automatic chk_dst(input string nm, input logic [3:0] e);
      for (int k = 0; k < 3; k++) chk($sformatf("%s_dst[%0d]", nm, k), act_b[k].dst, e);
   endtask

   // Asserts reset mid-cycle, checks outputs clear at once, releases after one edge.
   task automatic do_reset(input string nm);
      #1;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_rst_ov[%0d]", nm, k), act_ov[k], 1'b0);
         chk($sformatf("%s_rst_out[%0d]", nm, k), act_b[k], '0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_ready({nm, "_after_rst"}, 1'b1);
   endtask

   function automatic logic [3:0] rnd_nib();
      return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
   endfunction

   function automatic logic [15:0] rnd_instr();
      logic [3:0] opc;
      opc = 4'($urandom_range(0, 15));
      if (opc == 4'hF && $urandom_range(0, 7) != 0) opc = 4'h0;
      return {opc, rnd_nib(), rnd_nib(), rnd_nib()};
   endfunction

   initial begin
      rst = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; wb_we = 1'b0;
      wb_dst = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Write R3 then read it through an ADD.
      step(0, 16'h0000, 1, 0, 1, 4'd3, 32'h1234);
      step(1, 16'h0234, 1, 0, 0, 4'd0, 32'h0);
      chk_ready("add_accept", 1'b1);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      chk_valid("add_out", 1'b1);
      for (int k = 0; k < 3; k++) chk($sformatf("add_rd1[%0d]", k), act_b[k].rd1, 32'h1234);

      // Load-use: one bubble, then the dependent ADD.
      step(1, 16'h8300, 1, 0, 0, 4'd0, 32'h0);
      step(1, 16'h0134, 1, 0, 0, 4'd0, 32'h0);
      chk_valid("lu_load", 1'b1);
      chk_ready("lu_stall", 1'b0);
      step(1, 16'h0134, 1, 0, 0, 4'd0, 32'h0);
      chk_valid("lu_bubble", 1'b0);
      chk_ready("lu_resume", 1'b1);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      chk_valid("lu_add", 1'b1);
      chk_dst("lu_add", 4'd1);

      // Back-pressure for three cycles.
      step(1, 16'h0567, 1, 0, 0, 4'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 16'h0789, 0, 0, 0, 4'd0, 32'h0);
         chk_valid("bp_hold", 1'b1);
         chk_dst("bp_hold", 4'd5);
         chk_ready("bp_hold", 1'b0);
      end
      step(1, 16'h0789, 1, 0, 0, 4'd0, 32'h0);
      chk_ready("bp_release", 1'b1);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      chk_dst("bp_next", 4'd7);

      // Write-back forwarding in the accept cycle.
      step(0, 16'h0000, 1, 0, 1, 4'd5, 32'h1111);
      step(1, 16'h0050, 1, 0, 1, 4'd5, 32'hBEEF);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      for (int k = 0; k < 3; k++)
         chk($sformatf("bypass_rd1[%0d]", k), act_b[k].rd1,
             (CFG_BY[k] != 0) ? 32'hBEEF : 32'h1111);

      // Held branch killed by flush.
      step(1, 16'hC000, 0, 0, 0, 4'd0, 32'h0);
      step(0, 16'h0000, 0, 0, 0, 4'd0, 32'h0);
      for (int k = 0; k < 3; k++) chk($sformatf("br_pc_src[%0d]", k), act_b[k].pc_src, 1'b1);
      step(0, 16'h0000, 0, 1, 0, 4'd0, 32'h0);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      chk_valid("flush", 1'b0);
      for (int k = 0; k < 3; k++) chk($sformatf("flush_pc_src[%0d]", k), act_b[k].pc_src, 1'b0);

      // Reset in the middle of a load-use stall.
      step(1, 16'h8300, 1, 0, 0, 4'd0, 32'h0);
      step(1, 16'h0134, 1, 0, 0, 4'd0, 32'h0);
      chk_ready("mid_stall", 1'b0);
      do_reset("mid_stall");

      // Halt is sticky until reset.
      step(1, 16'hF000, 1, 0, 0, 4'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1, 16'h0111, 1, 0, 0, 4'd0, 32'h0);
         chk_ready("halted", 1'b0);
      end
      do_reset("halt");

      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), rnd_nib(), $urandom());
         end
         do_reset("rand");
      end

      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      step(0, 16'h0000, 1, 0, 0, 4'd0, 32'h0);
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
